// File: rtl/delay_timer_arbiter_pkg.sv
// Shared types and helpers for the delay_timer_arbiter block: FSM states,
// prescale presets and the round-robin pick function.
package delay_timer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned PRESCALE_1HZ = 100_000_000;
    localparam int unsigned PRESCALE_SIM = 4;

    // One-hot of the first set request at or after ptr, wrapping modulo n (n <= 8).
    function automatic logic [7:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int unsigned n);
        logic [7:0] oh;
        logic [2:0] j;
        logic       found;
        oh    = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < n && !found) begin
                j = 3'((32'(ptr) + k) % n);
                if (req[j]) begin
                    oh[j] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/delay_timer_arbiter_tick.sv
// Tick prescaler: counts 0..PRESCALE-1 while enabled and pulses tick on the
// last count; clr forces the count back to zero.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned PRE_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic             tick,
    output logic [PRE_W-1:0] count
);

    localparam logic [PRE_W-1:0] LAST_CNT = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] count_q;
    logic [PRE_W-1:0] count_d;

    assign tick  = en && (count_q == LAST_CNT);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter sharing one prescaled tick timer between NUM_REQ requesters.
// Optional LED half-period output enabled by defining DELAY_TIMER_ARBITER_LED_EN.
module delay_timer_arbiter
    import delay_timer_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DLY_W    = 8,
    parameter int unsigned PRESCALE = PRESCALE_1HZ,
    parameter int unsigned PRE_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*DLY_W-1:0] dly,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
`ifdef DELAY_TIMER_ARBITER_LED_EN
    output logic                     led,
`endif
    output logic                     tick
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PRE_W-1:0] LAST_CNT = PRE_W'(PRESCALE - 1);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [DLY_W-1:0]   rem_q, rem_d;

    logic [7:0]         pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   rr_next;
    logic               pre_clr;
    logic               pre_en;
    logic               pre_tick;
    logic [PRE_W-1:0]   pre_count;
    logic               last_cycle;

    tick_prescaler #(
        .PRESCALE (PRESCALE),
        .PRE_W    (PRE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clr   (pre_clr),
        .en    (pre_en),
        .tick  (pre_tick),
        .count (pre_count)
    );

    assign last_cycle = (pre_count == LAST_CNT);
    assign rr_next    = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        pick_oh  = rr_pick(8'(req), 3'(rr_q), NUM_REQ);
        pick_idx = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (pick_oh[k]) begin
                pick_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        rem_d   = rem_q;
        pre_clr = 1'b0;
        pre_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                pre_clr = 1'b1;
                if (|req) begin
                    gnt_d   = pick_oh[NUM_REQ-1:0];
                    idx_d   = pick_idx;
                    rem_d   = dly[pick_idx*DLY_W +: DLY_W];
                    state_d = (rem_d == '0) ? DONE : COUNT;
                end
            end
            COUNT: begin
                // An abort wins over a tick landing in the same cycle, so a
                // dropped request never sees a final tick or done.
                if (!req[idx_q]) begin
                    gnt_d   = '0;
                    rr_d    = rr_next;
                    pre_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    pre_en = 1'b1;
                    if (last_cycle && rem_q != '0) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == DLY_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                gnt_d   = '0;
                rr_d    = rr_next;
                pre_clr = 1'b1;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            rr_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            rem_q   <= rem_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = (state_q == DONE) ? gnt_q : '0;
    assign busy = (state_q != IDLE);
    assign tick = pre_tick;

`ifdef DELAY_TIMER_ARBITER_LED_EN
    localparam logic [PRE_W-1:0] HALF_CNT = PRE_W'(PRESCALE / 2);
    assign led = busy && (pre_count < HALF_CNT);
`endif

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Directed bench for delay_timer_arbiter with a scoreboard: expected done/tick
// events are queued by the stimulus and popped by an independent monitor.
module tb_delay_timer_arbiter;
    import delay_timer_arbiter_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  vec;
    } done_ev_t;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] dly;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   done;
    logic            busy;
    logic            tick;
`ifdef DELAY_TIMER_ARBITER_LED_EN
    logic            led;
`endif

    int unsigned cyc;
    int unsigned nchk;
    int unsigned nerr;
    done_ev_t    exp_done_q[$];
    int unsigned exp_tick_q[$];

    delay_timer_arbiter #(
        .NUM_REQ  (NR),
        .DLY_W    (DW),
        .PRESCALE (PRESCALE_SIM),
        .PRE_W    (32)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .dly  (dly),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
`ifdef DELAY_TIMER_ARBITER_LED_EN
        .led  (led),
`endif
        .tick (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%0h required=%0h (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic go_to(input int unsigned n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_dly(input int unsigned i, input logic [DW-1:0] v);
        dly[i*DW +: DW] = v;
    endtask

    task automatic push_done(input int unsigned c, input logic [3:0] v);
        done_ev_t ev;
        ev.cyc = c;
        ev.vec = v;
        exp_done_q.push_back(ev);
    endtask

    task automatic check_gnt(input int unsigned c, input logic [3:0] exp_gnt, input logic exp_busy);
        go_to(c);
        @(negedge clk);
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("busy", 32'(busy), 32'(exp_busy));
    endtask

    // Monitor: every done/tick pulse the DUT presents is matched against the queues.
    always @(negedge clk) begin
        done_ev_t    ev;
        int unsigned tc;
        if (done !== '0) begin
            if (exp_done_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL done_unexpected: actual=%b required=none (cyc=%0d)", done, cyc);
            end else begin
                ev = exp_done_q.pop_front();
                check("done_cycle", cyc, ev.cyc);
                check("done_vec", 32'(done), 32'(ev.vec));
            end
        end
        if (tick !== 1'b0) begin
            if (exp_tick_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL tick_unexpected: actual=%b required=0 (cyc=%0d)", tick, cyc);
            end else begin
                tc = exp_tick_q.pop_front();
                check("tick_cycle", cyc, tc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit (cyc=%0d)", cyc);
        $fatal(1);
    end

    initial begin
        nchk = 0;
        nerr = 0;
        rst  = 1'b0;
        req  = '0;
        dly  = '0;

        // Reset state
        #2;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tick", 32'(tick), 0);
        go_to(2);
        rst = 1'b1;

        // Idle for 50 cycles: no grant, no tick (monitor flags any tick)
        check_gnt(52, 4'b0000, 1'b0);

        // All requesters, dly=1: grants 0,1,2,3,0 with one idle cycle between
        go_to(60);
        for (int unsigned i = 0; i < NR; i++) set_dly(i, 8'd1);
        req = 4'b1111;
        for (int unsigned n = 0; n < 5; n++) begin
            exp_tick_q.push_back(64 + 6 * n);
            push_done(65 + 6 * n, 4'(1 << (n % 4)));
        end
        for (int unsigned n = 0; n < 5; n++) begin
            check_gnt(61 + 6 * n, 4'(1 << (n % 4)), 1'b1);
            if (n == 4) begin
                go_to(89);
                req = 4'b0000;
            end
            check_gnt(66 + 6 * n, 4'b0000, 1'b0);
        end

        // Zero delay on requester 1 (pointer now 1): done during the single grant cycle
        go_to(100);
        set_dly(1, 8'd0);
        req = 4'b0010;
        push_done(101, 4'b0010);
        check_gnt(101, 4'b0010, 1'b1);
        req = 4'b0000;
        check_gnt(102, 4'b0000, 1'b0);

        // Requester 2, dly=3: ticks at +4,+8,+12, done at +13, released at +14
        go_to(110);
        set_dly(2, 8'd3);
        req = 4'b0100;
        exp_tick_q.push_back(114);
        exp_tick_q.push_back(118);
        exp_tick_q.push_back(122);
        push_done(123, 4'b0100);
        check_gnt(111, 4'b0100, 1'b1);
        go_to(123);
        req = 4'b0000;
        check_gnt(124, 4'b0000, 1'b0);

        // Abort: requester 3, dly=5, request dropped 7 cycles in
        go_to(130);
        set_dly(3, 8'd5);
        req = 4'b1000;
        exp_tick_q.push_back(134);
        check_gnt(131, 4'b1000, 1'b1);
        go_to(137);
        req = 4'b0000;
        check_gnt(137, 4'b1000, 1'b1);
        check_gnt(138, 4'b0000, 1'b0);

        // Pointer advanced past 3 on abort: requester 0 wins over 3; dly change after grant ignored
        go_to(140);
        set_dly(0, 8'd1);
        set_dly(3, 8'd1);
        req = 4'b1001;
        exp_tick_q.push_back(144);
        push_done(145, 4'b0001);
        exp_tick_q.push_back(150);
        push_done(151, 4'b1000);
        check_gnt(141, 4'b0001, 1'b1);
        go_to(145);
        req = 4'b1000;
        check_gnt(147, 4'b1000, 1'b1);
        go_to(148);
        set_dly(3, 8'd9);
        go_to(151);
        req = 4'b0000;
        check_gnt(152, 4'b0000, 1'b0);

        // Asynchronous reset mid-COUNT, then restart with the full delay
        go_to(160);
        set_dly(2, 8'd3);
        req = 4'b0100;
        exp_tick_q.push_back(164);
        check_gnt(161, 4'b0100, 1'b1);
        go_to(165);
        #2;
        rst = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt), 0);
        check("arst_done", 32'(done), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_tick", 32'(tick), 0);
        go_to(168);
        rst = 1'b1;
        exp_tick_q.push_back(172);
        exp_tick_q.push_back(176);
        exp_tick_q.push_back(180);
        push_done(181, 4'b0100);
        check_gnt(169, 4'b0100, 1'b1);
        go_to(181);
        req = 4'b0000;
        check_gnt(182, 4'b0000, 1'b0);

        // Every expected event must have been seen
        go_to(190);
        @(negedge clk);
        check("done_q_left", exp_done_q.size(), 0);
        check("tick_q_left", exp_tick_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
